// File: rtl/stage1_ifq.sv
// stage1_ifq: instruction fetch stage with a small prefetch queue.
// A three-state fetch FSM issues one memory request at a time. Returned words
// are queued together with their fall-through PC. A registered output stage
// feeds decode from the queue, or inserts a bubble on redirect, flush or empty.
module stage1_ifq #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    QDEPTH     = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h00400020,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  pc_src,
  input  logic [DATA_WIDTH-1:0] pc_target,
  input  logic                  hold_pc,
  input  logic                  hold_if,
  input  logic                  if_flush,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  instr_valid
);

  localparam int                    AW      = $clog2(QDEPTH);
  localparam logic [AW:0]           DEPTH_C = (AW+1)'(QDEPTH);
  localparam logic [DATA_WIDTH-1:0] STEP_C  = DATA_WIDTH'(PC_STEP);

  // DROP: a request is still on the bus but its data belongs to a dead path.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [DATA_WIDTH-1:0]   fetch_pc_r, fetch_pc_s;
  logic [DATA_WIDTH-1:0]   addr_r, addr_s;
  logic                    req_r;
  logic [DATA_WIDTH-1:0]   q_pc4_r [QDEPTH];
  logic [DATA_WIDTH-1:0]   q_ins_r [QDEPTH];
  logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
  logic [AW:0]             count_r, count_s;
  logic                    push_s, pop_s, bubble_s;
  logic [DATA_WIDTH-1:0]   instr_r, pc_plus4_r;
  logic                    instr_valid_r;

  assign imem_req    = req_r;
  assign imem_addr   = addr_r;
  assign instr       = instr_r;
  assign pc_plus4    = pc_plus4_r;
  assign instr_valid = instr_valid_r;

  // Queue push/pop decisions and next occupancy (a redirect empties the queue).
  always_comb begin
    push_s   = (state_r == S_REQ) & req_r & imem_ack & ~pc_src;
    bubble_s = pc_src | if_flush | (count_r == {(AW+1){1'b0}});
    pop_s    = ~hold_if & ~bubble_s;
    if (pc_src) begin
      count_s = {(AW+1){1'b0}};
    end else begin
      count_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end
  end

  // Fetch FSM next state, next fetch PC and next request address.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    case (state_r)
      S_IDLE: begin
        if (pc_src) begin
          fetch_pc_s = pc_target;
          state_s    = S_IDLE;
        end else if (~hold_pc && (count_r < DEPTH_C)) begin
          state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (pc_src) begin
          fetch_pc_s = pc_target;
          state_s    = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          fetch_pc_s = fetch_pc_r + STEP_C;
          state_s    = ((count_s < DEPTH_C) && ~hold_pc) ? S_REQ : S_IDLE;
        end else begin
          state_s = S_REQ;
        end
      end
      S_DROP: begin
        if (pc_src) begin
          fetch_pc_s = pc_target;
        end else begin
          fetch_pc_s = fetch_pc_r;
        end
        state_s = imem_ack ? S_IDLE : S_DROP;
      end
      default: begin
        state_s    = S_IDLE;
        fetch_pc_s = fetch_pc_r;
      end
    endcase
    // The bus address must not move while a dropped request is still pending.
    if (state_s == S_DROP) begin
      addr_s = addr_r;
    end else begin
      addr_s = fetch_pc_s;
    end
  end

  // Fetch FSM state, fetch PC and request outputs.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_r    <= S_IDLE;
      fetch_pc_r <= RESET_PC;
      addr_r     <= RESET_PC;
      req_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      addr_r     <= addr_s;
      req_r      <= (state_s != S_IDLE);
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at QDEPTH.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (pc_src) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      count_r <= count_s;
    end
  end

  // Queue storage: fetched word plus its fall-through PC.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_ins_r[wr_ptr_r] <= imem_rdata;
      q_pc4_r[wr_ptr_r] <= fetch_pc_r + STEP_C;
    end
  end

  // Output register toward decode: pop the head or load a bubble.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      instr_r       <= {DATA_WIDTH{1'b0}};
      pc_plus4_r    <= {DATA_WIDTH{1'b0}};
      instr_valid_r <= 1'b0;
    end else if (!hold_if) begin
      if (bubble_s) begin
        instr_r       <= {DATA_WIDTH{1'b0}};
        pc_plus4_r    <= {DATA_WIDTH{1'b0}};
        instr_valid_r <= 1'b0;
      end else begin
        instr_r       <= q_ins_r[rd_ptr_r];
        pc_plus4_r    <= q_pc4_r[rd_ptr_r];
        instr_valid_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stage1_ifq.sv
// tb_stage1_ifq: directed vector table, hand-written hold/reset sequences and a
// randomized run against a queue-based reference model of the fetch stage.
module tb_stage1_ifq;

  localparam logic [31:0] RST_PC = 32'h00400020;
  localparam logic [31:0] TGT    = 32'h00400100;

  logic        clk, rstb, pc_src, hold_pc, hold_if, if_flush, imem_ack;
  logic [31:0] pc_target, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc_plus4;

  int tests;
  int fails;

  stage1_ifq #(.DATA_WIDTH(32), .QDEPTH(4), .RESET_PC(32'h00400020), .PC_STEP(4)) dut (
    .clk(clk), .rstb(rstb), .pc_src(pc_src), .pc_target(pc_target),
    .hold_pc(hold_pc), .hold_if(hold_if), .if_flush(if_flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstb, pc_src, ack;
    logic [31:0] rdata;
    logic        chk, e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc4;
  } vec_t;

  vec_t tv [19];

  function automatic vec_t mk(input logic r, ps, ak, input logic [31:0] rd,
                              input logic c, er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ei, ep);
    vec_t v;
    v.rstb = r; v.pc_src = ps; v.ack = ak; v.rdata = rd; v.chk = c; v.e_req = er;
    v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic r, ps, hp, hi, fl, ak, input logic [31:0] tg, rd);
    rstb = r; pc_src = ps; hold_pc = hp; hold_if = hi; if_flush = fl;
    imem_ack = ak; pc_target = tg; imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: outstanding-request view of the fetch stage.
  logic        m_req, m_drop, m_valid;
  logic [31:0] m_addr, m_pc, m_instr, m_pc4;
  logic [31:0] mq_ins[$];
  logic [31:0] mq_pc4[$];

  task automatic model_edge();
    int size0;
    size0 = mq_ins.size();
    if (!rstb) begin
      m_req = 1'b0; m_drop = 1'b0; m_pc = RST_PC; m_addr = RST_PC;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      mq_ins.delete(); mq_pc4.delete();
    end else begin
      if (!hold_if) begin
        if (pc_src || if_flush || size0 == 0) begin
          m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
          m_instr = mq_ins.pop_front(); m_pc4 = mq_pc4.pop_front(); m_valid = 1'b1;
        end
      end
      if (pc_src) begin
        mq_ins.delete(); mq_pc4.delete();
        m_pc = pc_target;
        if (m_req && !imem_ack) m_drop = 1'b1;
        else begin m_req = 1'b0; m_drop = 1'b0; m_addr = m_pc; end
      end else if (m_req && imem_ack) begin
        if (m_drop) begin
          m_drop = 1'b0; m_req = 1'b0; m_addr = m_pc;
        end else begin
          mq_ins.push_back(imem_rdata); mq_pc4.push_back(m_pc + 32'd4);
          m_pc = m_pc + 32'd4; m_addr = m_pc;
          m_req = (mq_ins.size() < 4) && !hold_pc;
        end
      end else if (!m_req && !hold_pc && size0 < 4) begin
        m_req = 1'b1; m_addr = m_pc;
      end
    end
  endtask

  initial begin
    logic [31:0] words[$];
    logic [31:0] got[$];
    int pushes;
    tests = 0; fails = 0;

    // Sequential fetch, 3-cycle ack delay, redirect while pending, redirect with ack.
    tv[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0);
    tv[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h00400020, 1'b0, 32'h0,         32'h0);
    tv[2]  = mk(1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h00400020, 1'b0, 32'h0,         32'h0);
    tv[3]  = mk(1'b1, 1'b0, 1'b1, 32'h11110000, 1'b1, 1'b1, 32'h00400020, 1'b0, 32'h0,         32'h0);
    tv[4]  = mk(1'b1, 1'b0, 1'b1, 32'h11110001, 1'b1, 1'b1, 32'h00400024, 1'b0, 32'h0,         32'h0);
    tv[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00400028, 1'b1, 32'h11110000, 32'h00400024);
    tv[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00400028, 1'b1, 32'h11110001, 32'h00400028);
    tv[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00400028, 1'b0, 32'h0,         32'h0);
    tv[8]  = mk(1'b1, 1'b0, 1'b1, 32'h11110003, 1'b1, 1'b1, 32'h00400028, 1'b0, 32'h0,         32'h0);
    tv[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040002c, 1'b0, 32'h0,         32'h0);
    tv[10] = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040002c, 1'b1, 32'h11110003, 32'h0040002c);
    tv[11] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0040002c, 1'b0, 32'h0,         32'h0);
    tv[12] = mk(1'b1, 1'b0, 1'b1, 32'hdeadbeef, 1'b1, 1'b1, 32'h0040002c, 1'b0, 32'h0,         32'h0);
    tv[13] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h00400100, 1'b0, 32'h0,         32'h0);
    tv[14] = mk(1'b1, 1'b1, 1'b1, 32'h44444444, 1'b1, 1'b1, 32'h00400100, 1'b0, 32'h0,         32'h0);
    tv[15] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h00400100, 1'b0, 32'h0,         32'h0);
    tv[16] = mk(1'b1, 1'b0, 1'b1, 32'h55555555, 1'b1, 1'b1, 32'h00400100, 1'b0, 32'h0,         32'h0);
    tv[17] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00400104, 1'b0, 32'h0,         32'h0);
    tv[18] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00400104, 1'b1, 32'h55555555, 32'h00400104);

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      set_in(tv[i].rstb, tv[i].pc_src, 1'b0, 1'b0, 1'b0, tv[i].ack, TGT, tv[i].rdata);
      if (tv[i].chk) begin
        chk($sformatf("tv%0d.req", i),   {31'h0, imem_req},    {31'h0, tv[i].e_req});
        chk($sformatf("tv%0d.addr", i),  imem_addr,            tv[i].e_addr);
        chk($sformatf("tv%0d.valid", i), {31'h0, instr_valid}, {31'h0, tv[i].e_valid});
        chk($sformatf("tv%0d.instr", i), instr,                tv[i].e_instr);
        chk($sformatf("tv%0d.pc4", i),   pc_plus4,             tv[i].e_pc4);
      end
      tick();
    end

    // hold_if for 10 cycles with ack tied high: exactly 4 pushes, then no request.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    pushes = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hb0000000 + 32'(i));
      if (imem_req) begin
        pushes++;
        words.push_back(imem_rdata);
      end
      tick();
    end
    chk("hold_if.pushes", 32'(pushes), 32'd4);
    chk("hold_if.req_dropped", {31'h0, imem_req}, 32'h0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (instr_valid) got.push_back(instr);
      tick();
    end
    chk("hold_if.count_out", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size() && i < words.size())
        chk($sformatf("hold_if.word%0d", i), got[i], words[i]);
    end

    // Reset in the middle of a pending request with 3 queued words.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hc0000001);
    tick(); tick(); tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hc0000002);
    tick(); tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("rst_mid.pending", {31'h0, imem_req}, 32'h1);
    chk("rst_mid.valid_before", {31'h0, instr_valid}, 32'h1);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("rst_mid.req", {31'h0, imem_req}, 32'h0);
    chk("rst_mid.addr", imem_addr, RST_PC);
    chk("rst_mid.valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_mid.instr", instr, 32'h0);
    chk("rst_mid.pc4", pc_plus4, 32'h0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("rst_mid.first_req", {31'h0, imem_req}, 32'h1);
    chk("rst_mid.first_addr", imem_addr, RST_PC);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_mid.empty%0d", i), {31'h0, instr_valid}, 32'h0);
    end

    // Randomized run against the reference model.
    m_req = 1'b0; m_drop = 1'b0; m_valid = 1'b0; m_addr = RST_PC; m_pc = RST_PC;
    m_instr = 32'h0; m_pc4 = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tg;
      tg = $urandom & 32'hfffffffc;
      if ($urandom_range(0, 3) == 0) tg = 32'hfffffff8;
      set_in((i < 2) ? 1'b0 : ($urandom_range(0, 99) >= 2),
             $urandom_range(0, 99) < 7, $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 55, tg, $urandom);
      if (i >= 1) begin
        chk($sformatf("rnd%0d.req", i),   {31'h0, imem_req},    {31'h0, m_req});
        chk($sformatf("rnd%0d.addr", i),  imem_addr,            m_addr);
        chk($sformatf("rnd%0d.valid", i), {31'h0, instr_valid}, {31'h0, m_valid});
        chk($sformatf("rnd%0d.instr", i), instr,                m_instr);
        chk($sformatf("rnd%0d.pc4", i),   pc_plus4,             m_pc4);
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
